// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of fetch-port, data-port and memory-side signals around mem_port_arb.
interface mem_port_arb_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_done;
    logic              if_stall;

    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_stall;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arb_lat_cnt.sv
// Loadable down-counter timing one memory access; saturates at zero, reload only on load.
module arb_lat_cnt #(
    parameter int LATENCY = 2,
    parameter int W       = $clog2(LATENCY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam logic [W-1:0] LOAD_VAL = W'(LATENCY - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LOAD_VAL;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arb.sv
// Fetch/data arbiter for the single-ported memory: issue->done LATENCY+1 cycles, one access in flight,
// losers see stall until their done. ARB_RR_EN selects round-robin on collisions, else data priority.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input logic           clk,
    input logic           rst,
    mem_port_arb_if.slave bus
);
    arb_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_if_data, r_dm_rdata;
    logic              r_if_done, r_dm_done, r_dm_is_wr;

    logic              w_if_elig, w_dm_elig, w_pick_dm;
    logic              w_issue, w_issue_dm, w_cnt_dec, w_cnt_zero;
    logic              w_if_cap, w_dm_cap;
    logic              w_mem_en, w_mem_wr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // A port whose done is pulsing is still holding req for this cycle; do not re-issue it.
    assign w_if_elig = bus.if_req & ~r_if_done;
    assign w_dm_elig = bus.dm_req & ~r_dm_done;

`ifdef ARB_RR_EN
    logic r_last_grant;
    assign w_pick_dm = w_dm_elig & (~w_if_elig | (r_last_grant == PORT_IF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_grant <= PORT_IF;
        else if (w_issue)
            r_last_grant <= w_issue_dm ? PORT_DM : PORT_IF;
    end
`else
    assign w_pick_dm = w_dm_elig;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_dm  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_if_cap    = 1'b0;
        w_dm_cap    = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    if (w_pick_dm) begin
                        w_issue     = 1'b1;
                        w_issue_dm  = 1'b1;
                        w_mem_en    = 1'b1;
                        w_mem_wr    = bus.dm_wr;
                        w_mem_addr  = bus.dm_addr;
                        w_mem_wdata = bus.dm_wdata;
                        w_state_nxt = BUSY_DM;
                    end else if (w_if_elig) begin
                        w_issue     = 1'b1;
                        w_mem_en    = 1'b1;
                        w_mem_addr  = bus.if_addr;
                        w_state_nxt = BUSY_IF;
                    end
                end
            end
            BUSY_IF: begin
                if (w_cnt_zero) begin
                    w_if_cap    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            BUSY_DM: begin
                if (w_cnt_zero) begin
                    w_dm_cap    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    arb_lat_cnt #(.LATENCY(LATENCY)) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_issue),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_if_data  <= '0;
            r_dm_rdata <= '0;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_dm_is_wr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_if_done <= w_if_cap;
            r_dm_done <= w_dm_cap;
            if (w_issue_dm)
                r_dm_is_wr <= bus.dm_wr;
            if (w_if_cap)
                r_if_data <= bus.mem_rdata;
            if (w_dm_cap && !r_dm_is_wr)
                r_dm_rdata <= bus.mem_rdata;
        end
    end

    assign bus.if_data   = r_if_data;
    assign bus.if_done   = r_if_done;
    assign bus.if_stall  = bus.if_req & ~r_if_done;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_done   = r_dm_done;
    assign bus.dm_stall  = bus.dm_req & ~r_dm_done;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb with a fixed-latency memory model (LATENCY=2).
module tb_mem_port_arb;
    import mem_arb_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arb_if bus();

    mem_port_arb #(.LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
    } done_t;

    iss_t  iss_q[$];
    done_t if_q[$];
    done_t dm_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [15:0] mem [256];
    int          resp_cyc = -1;
    logic [15:0] resp_dat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: read data appears only in the cycle LAT after issue, garbage otherwise.
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = (cyc == resp_cyc) ? resp_dat : 16'hDEAD;
    end

    // Monitor: compares everything the DUT presents against the queued expectations.
    always @(negedge clk) begin
        logic exp_if_done, exp_dm_done;
        iss_t  e;
        done_t d;
        exp_if_done = (if_q.size() > 0) && (if_q[0].cyc == cyc);
        exp_dm_done = (dm_q.size() > 0) && (dm_q[0].cyc == cyc);

        if (!bus.mem_en) begin
            chk("mem_wr_idle", 32'(bus.mem_wr), 32'd0);
            chk("mem_bus_idle", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        end else if (iss_q.size() == 0) begin
            chk("issue_unexpected", 32'(bus.mem_en), 32'd0);
        end else begin
            e = iss_q.pop_front();
            chk("issue_cycle", 32'(cyc), 32'(e.cyc));
            chk("issue_wr", 32'(bus.mem_wr), 32'(e.wr));
            chk("issue_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("issue_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
            if (bus.mem_wr) begin
                mem[bus.mem_addr[7:0]] = bus.mem_wdata;
            end else begin
                resp_cyc = cyc + LAT;
                resp_dat = mem[bus.mem_addr[7:0]];
            end
        end

        chk("if_done", 32'(bus.if_done), 32'(exp_if_done));
        if (exp_if_done) begin
            d = if_q.pop_front();
            if (bus.if_done) chk("if_data", 32'(bus.if_data), 32'(d.dat));
        end
        chk("dm_done", 32'(bus.dm_done), 32'(exp_dm_done));
        if (exp_dm_done) begin
            d = dm_q.pop_front();
            if (bus.dm_done) chk("dm_rdata", 32'(bus.dm_rdata), 32'(d.dat));
        end

        chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~exp_if_done));
        chk("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req & ~exp_dm_done));
    end

    // Requesters drop req in their done cycle; returns once both are idle.
    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.if_done) bus.if_req = 1'b0;
            if (bus.dm_done) bus.dm_req = 1'b0;
            if (!bus.if_req && !bus.dm_req) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout: requests still pending after %0d cycles", budget);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n_done;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hA5A5;
        mem[8'h20] = 16'h5A5A;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_wr    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        // Reset state, including a request held during reset
        repeat (2) @(negedge clk);
        chk("rst_if_data", 32'(bus.if_data), 32'd0);
        chk("rst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_dm_done", 32'(bus.dm_done), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        bus.if_req = 1'b1;
        @(negedge clk);
        chk("rst_req_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_req_if_stall", 32'(bus.if_stall), 32'd1);
        bus.if_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single fetch
        tick();
        t0 = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        iss_q.push_back('{t0, 1'b0, 16'h0010, 16'h0000});
        if_q.push_back('{t0 + 3, 16'hA5A5});
        drain(20);

        // Data write; port inputs change after issue and must be ignored
        tick();
        t0 = cyc;
        bus.dm_req   = 1'b1;
        bus.dm_wr    = 1'b1;
        bus.dm_addr  = 16'h0200;
        bus.dm_wdata = 16'h1234;
        iss_q.push_back('{t0, 1'b1, 16'h0200, 16'h1234});
        dm_q.push_back('{t0 + 3, 16'h0000});
        tick();
        bus.dm_wr    = 1'b0;
        bus.dm_addr  = 16'hFFFF;
        bus.dm_wdata = 16'hBEEF;
        drain(20);

        // Data read back of the written word
        tick();
        t0 = cyc;
        bus.dm_req   = 1'b1;
        bus.dm_wr    = 1'b0;
        bus.dm_addr  = 16'h0200;
        bus.dm_wdata = 16'h0000;
        iss_q.push_back('{t0, 1'b0, 16'h0200, 16'h0000});
        dm_q.push_back('{t0 + 3, 16'h1234});
        drain(20);

        // Simultaneous requests; last grant was data
        tick();
        t0 = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        bus.dm_req  = 1'b1;
        bus.dm_wr   = 1'b0;
        bus.dm_addr = 16'h0020;
`ifdef ARB_RR_EN
        iss_q.push_back('{t0, 1'b0, 16'h0010, 16'h0000});
        iss_q.push_back('{t0 + 3, 1'b0, 16'h0020, 16'h0000});
        if_q.push_back('{t0 + 3, 16'hA5A5});
        dm_q.push_back('{t0 + 6, 16'h5A5A});
`else
        iss_q.push_back('{t0, 1'b0, 16'h0020, 16'h0000});
        iss_q.push_back('{t0 + 3, 1'b0, 16'h0010, 16'h0000});
        dm_q.push_back('{t0 + 3, 16'h5A5A});
        if_q.push_back('{t0 + 6, 16'hA5A5});
`endif
        drain(30);

        // Data request held high across three accesses: no re-issue in done cycles
        tick();
        t0 = cyc;
        bus.dm_req  = 1'b1;
        bus.dm_wr   = 1'b0;
        bus.dm_addr = 16'h0020;
        for (int k = 0; k < 3; k++) begin
            iss_q.push_back('{t0 + 4 * k, 1'b0, 16'h0020, 16'h0000});
            dm_q.push_back('{t0 + 4 * k + 3, 16'h5A5A});
        end
        n_done = 0;
        for (int i = 0; i < 40 && n_done < 3; i++) begin
            tick();
            if (bus.dm_done) n_done++;
        end
        bus.dm_req = 1'b0;
        chk("cont_done_count", 32'(n_done), 32'd3);

        // Reset in the middle of a fetch
        tick();
        t0 = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        iss_q.push_back('{t0, 1'b0, 16'h0010, 16'h0000});
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_if_data", 32'(bus.if_data), 32'd0);
        chk("midrst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
        chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("midrst_if_stall", 32'(bus.if_stall), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        t0 = cyc;
        iss_q.push_back('{t0, 1'b0, 16'h0010, 16'h0000});
        if_q.push_back('{t0 + 3, 16'hA5A5});
        drain(20);

        repeat (6) tick();
        chk("iss_q_empty", 32'(iss_q.size()), 32'd0);
        chk("if_q_empty", 32'(if_q.size()), 32'd0);
        chk("dm_q_empty", 32'(dm_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer sharing the single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline. It grants one access at a time, counts out the memory latency, returns read data with a one-cycle done pulse, and drives per-port stall lines consumed alongside the hazard/NOP logic. Default policy gives the data port priority because it belongs to the older instruction.

## Interface
- LATENCY, 2, cycles from issue to valid mem_rdata; legal range 1..15
- clk  in  1  clock, all state rising-edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  16  fetch address
- if_data  out  16  fetched instruction, registered
- if_done  out  1  one-cycle pulse, if_data valid this cycle
- if_stall  out  1  fetch must hold
- dm_req  in  1  data request, level, held until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  16  data address
- dm_wdata  in  16  write data
- dm_rdata  out  16  read data, registered
- dm_done  out  1  one-cycle pulse, access complete
- dm_stall  out  1  memory stage must hold
- mem_en  out  1  issue strobe, one cycle per access
- mem_wr  out  1  write strobe, qualified by mem_en
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid LATENCY cycles after issue

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE: eligible requester = req high and its done not high this cycle (prevents re-issue of a completing request). If data eligible -> issue data; else if fetch eligible -> issue fetch; else stay.
- Issue cycle (in IDLE): mem_en=1, mem_addr/mem_wr/mem_wdata from the granted port (mem_wr=0 for fetch); counter loaded with LATENCY-1; next state BUSY_x.
- mem_addr/mem_wr/mem_wdata are 0 when mem_en=0.
- BUSY_x: counter decrements; in the cycle counter==0 and mem_rdata valid, latch mem_rdata into if_data (fetch) or dm_rdata (data read; writes leave dm_rdata unchanged), set the matching done for next cycle, next state IDLE.
- if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done (combinational).
- Request dropped mid-access: access completes, done still pulses, no other effect.
- Address/data inputs sampled only on the issue cycle; later changes ignored.
- Counter width ceil(log2(LATENCY+1)) bits, no wrap: reload only on issue.

## Timing
- Reset: state IDLE, counter 0, if_data=0, dm_rdata=0, if_done=0, dm_done=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0; stalls follow reqs.
- Issue at cycle t -> mem_rdata valid t+LATENCY -> done pulse and data at t+LATENCY+1.
- Done cycle is IDLE: the other port may issue in it; peak throughput one access per LATENCY+1 cycles.
- Both requests in same IDLE cycle: one grant, the other waits through the full access.
- Reset mid-access: in-flight access abandoned, no done pulse, ports re-request after reset.

## Configuration
- ARB_RR_EN defined: one-bit last-grant register (reset: fetch). On a simultaneous request, grant the port not granted last; single requests granted immediately.
- ARB_RR_EN undefined: fixed data priority; fetch can starve while data requests continue.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_DM), port-id constants (PORT_IF, PORT_DM), 16-bit address/data width constants.
- One sub-module: arb_lat_cnt (loadable down-counter, load/dec/zero flag, width from LATENCY).

## Test plan
- Single fetch, LATENCY=2: if_req at t0, if_addr=0x0010, mem_rdata=0xA5A5 at t2 -> mem_en at t0 only, if_done and if_data=0xA5A5 at t3, if_stall high t0-t2.
- Data write: dm_req, dm_wr=1, dm_addr=0x0200, dm_wdata=0x1234 -> mem_en=mem_wr=1 with those values at t0, dm_done at t3, dm_rdata unchanged.
- Simultaneous if_req/dm_req (priority build) -> data issued t0, done t3; fetch issued t3, if_done t6.
- Same with ARB_RR_EN, last grant data -> fetch issued t0, data issued t3.
- Continuous dm_req with no done masking -> verify no re-issue of the completing port in its done cycle.
- rst asserted at t1 of a read -> all outputs 0 immediately, no done pulse; after release, re-request completes normally.
